// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and index-width helpers
package cache_pkg;
  localparam int WAYS_DEF = 8;
  localparam int LINE_BITS_DEF = 512;
  localparam int WORD_BITS_DEF = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cache_line_select_pipe_if.sv
// cache_line_select_pipe_if: request and response bus of the way-select pipeline
interface cache_line_select_pipe_if
  import cache_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
);
  localparam int SEL_W = idx_w(WAYS);
  localparam int OFF_W = idx_w(LINE_BITS / WORD_BITS);
  logic in_valid;
  logic in_ready;
  logic [WAYS*LINE_BITS-1:0] lines;
  logic [SEL_W-1:0] way_sel;
  logic [OFF_W-1:0] word_off;
  logic hit;
  logic out_valid;
  logic out_ready;
  logic [LINE_BITS-1:0] out_line;
  logic [WORD_BITS-1:0] out_word;
  logic out_hit;
  logic out_err;
  modport master (
    output in_valid, lines, way_sel, word_off, hit, out_ready,
    input in_ready, out_valid, out_line, out_word, out_hit, out_err
  );
  modport slave (
    input in_valid, lines, way_sel, word_off, hit, out_ready,
    output in_ready, out_valid, out_line, out_word, out_hit, out_err
  );
endinterface

// File: rtl/cache_pipe_stage.sv
// cache_pipe_stage: one valid/ready register slice without skid buffer
module cache_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (in_valid && in_ready) out_data <= in_data;
    end
  end
endmodule

// File: rtl/cache_line_select_pipe.sv
// cache_line_select_pipe: way mux into S1, word extraction into S2, valid/ready between
module cache_line_select_pipe
  import cache_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input logic clk,
  input logic reset,
  cache_line_select_pipe_if.slave bus
);
  localparam int SEL_W = idx_w(WAYS);
  localparam int WORDS = LINE_BITS / WORD_BITS;
  localparam int OFF_W = idx_w(WORDS);
  localparam int S1_W = LINE_BITS + OFF_W + 2;
  localparam int S2_W = LINE_BITS + WORD_BITS + 2;
  logic [LINE_BITS-1:0] sel_line, s1_line;
  logic [WORD_BITS-1:0] s1_word;
  logic [OFF_W-1:0] s1_off;
  logic sel_err, s1_hit, s1_err, s1_valid, s1_ready;
  // an out-of-range index matches no way, so the line falls back to zero
  always_comb begin
    sel_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (bus.way_sel == SEL_W'(w)) sel_line = bus.lines[w*LINE_BITS +: LINE_BITS];
  end
  assign sel_err = {1'b0, bus.way_sel} >= (SEL_W+1)'(WAYS);
  cache_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(clk),
    .reset(reset),
    .in_valid(bus.in_valid),
    .in_ready(bus.in_ready),
    .in_data({sel_line, bus.word_off, bus.hit & ~sel_err, sel_err}),
    .out_valid(s1_valid),
    .out_ready(s1_ready),
    .out_data({s1_line, s1_off, s1_hit, s1_err})
  );
  always_comb begin
    s1_word = '0;
    for (int i = 0; i < WORDS; i++)
      if (s1_off == OFF_W'(i)) s1_word = s1_line[i*WORD_BITS +: WORD_BITS];
  end
  cache_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(clk),
    .reset(reset),
    .in_valid(s1_valid),
    .in_ready(s1_ready),
    .in_data({s1_line, s1_word, s1_hit, s1_err}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data({bus.out_line, bus.out_word, bus.out_hit, bus.out_err})
  );
endmodule
